// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, memory-wait freeze,
// multi-cycle flush after a taken jump, plus a saturating stall counter and sticky timeout flag.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             read_mem_ex,
  input  logic             jmp_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_stall_req,
  output logic             flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [1:0]  FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT    = 16'(MEM_TIMEOUT);

  state_t           state_reg, state_next;
  logic [1:0]       fcnt_reg, fcnt_next;
  logic [15:0]      wcnt_reg, wcnt_next;
  logic             jmp_pend_reg, jmp_pend_next;
  logic             mem_timeout_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic load_use, mem_wait;
  logic pc_stall_c, if_id_stall_c, id_stall_req_c, flush_c;

  assign load_use = read_mem_ex && (rd_ex != 5'd0) &&
                    ((uses_rs1_id && (rs1_id == rd_ex)) || (uses_rs2_id && (rs2_id == rd_ex)));
  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    state_next     = state_reg;
    fcnt_next      = fcnt_reg;
    wcnt_next      = wcnt_reg;
    jmp_pend_next  = jmp_pend_reg;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_stall_req_c = 1'b0;
    flush_c        = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_wait) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          jmp_pend_next = jmp_taken_ex;
          fcnt_next     = 2'd0;
          wcnt_next     = 16'd1;
          state_next    = MEM_WAIT;
        end else if (jmp_taken_ex) begin
          flush_c = 1'b1;
          if (FLUSH_LAST != 2'd0) begin
            fcnt_next  = FLUSH_LAST;
            state_next = FLUSH;
          end
        end else if (load_use) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_stall_req_c = 1'b1;
        end
      end
      FLUSH: begin
        // A memory wait suspends the flush; the remaining count rides along into MEM_WAIT.
        if (mem_wait) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          jmp_pend_next = 1'b0;
          wcnt_next     = 16'd1;
          state_next    = MEM_WAIT;
        end else begin
          flush_c   = 1'b1;
          fcnt_next = fcnt_reg - 2'd1;
          if (fcnt_reg <= 2'd1) state_next = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          if (wcnt_reg != 16'hFFFF) wcnt_next = wcnt_reg + 16'd1;
        end else begin
          wcnt_next     = 16'd0;
          jmp_pend_next = 1'b0;
          state_next    = RUN;
          if (jmp_pend_reg) begin
            flush_c   = 1'b1;
            fcnt_next = FLUSH_LAST;
            if (FLUSH_LAST != 2'd0) state_next = FLUSH;
          end else if (fcnt_reg != 2'd0) begin
            flush_c   = 1'b1;
            fcnt_next = fcnt_reg - 2'd1;
            if (fcnt_reg > 2'd1) state_next = FLUSH;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign pc_stall     = rst_n & pc_stall_c;
  assign if_id_stall  = rst_n & if_id_stall_c;
  assign id_stall_req = rst_n & id_stall_req_c;
  assign flush        = rst_n & flush_c;
  assign mem_timeout  = mem_timeout_reg;
  assign stall_cycles = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      fcnt_reg        <= 2'd0;
      wcnt_reg        <= 16'd0;
      jmp_pend_reg    <= 1'b0;
      mem_timeout_reg <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fcnt_reg     <= fcnt_next;
      wcnt_reg     <= wcnt_next;
      jmp_pend_reg <= jmp_pend_next;
      // wcnt_next is zero whenever no wait is in progress, so this only fires mid-wait.
      if (wcnt_next >= TIMEOUT) mem_timeout_reg <= 1'b1;
      if (pc_stall && (stall_cnt_reg != {CNT_W{1'b1}})) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dut_a (FLUSH_CYCLES=2, defaults otherwise) and
// dut_b (FLUSH_CYCLES=3, MEM_TIMEOUT=3, CNT_W=4) share stimulus but have separate resets.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic uses_rs1_id, uses_rs2_id, read_mem_ex, jmp_taken_ex, mem_req, mem_ready;

  logic pc_stall_a, if_id_stall_a, id_stall_req_a, flush_a, mem_timeout_a;
  logic [15:0] stall_cycles_a;
  logic pc_stall_b, if_id_stall_b, id_stall_req_b, flush_b, mem_timeout_b;
  logic [3:0] stall_cycles_b;

  int n_pass = 0;
  int n_total = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .read_mem_ex(read_mem_ex), .jmp_taken_ex(jmp_taken_ex), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a),
    .id_stall_req(id_stall_req_a), .flush(flush_a), .mem_timeout(mem_timeout_a),
    .stall_cycles(stall_cycles_a)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .read_mem_ex(read_mem_ex), .jmp_taken_ex(jmp_taken_ex), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b),
    .id_stall_req(id_stall_req_b), .flush(flush_b), .mem_timeout(mem_timeout_b),
    .stall_cycles(stall_cycles_b)
  );

  // Control nibble: {pc_stall, if_id_stall, id_stall_req, flush}
  wire [3:0] ctl_a = {pc_stall_a, if_id_stall_a, id_stall_req_a, flush_a};
  wire [3:0] ctl_b = {pc_stall_b, if_id_stall_b, id_stall_req_b, flush_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; read_mem_ex = 1'b0;
    jmp_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic lu_rs2(input logic [4:0] rd);
    rd_ex = rd; rs2_id = rd; uses_rs2_id = 1'b1; read_mem_ex = 1'b1;
  endtask

  initial begin
    clr();
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    tick();
    tick();
    // Reset: controls gated even with a hazard present
    lu_rs2(5'd5);
    #1 chk("rst_ctl_a", 32'(ctl_a), 32'h0);
    chk("rst_stall_a", 32'(stall_cycles_a), 32'd0);
    chk("rst_tmo_a", 32'(mem_timeout_a), 32'd0);
    clr();
    rst_n_a = 1'b1;
    tick();

    // Load-use on rs2
    lu_rs2(5'd5);
    #1 chk("lu_rs2_ctl", 32'(ctl_a), 32'b1110);
    tick();
    read_mem_ex = 1'b0;
    #1 chk("lu_after_ctl", 32'(ctl_a), 32'h0);
    chk("lu_stall_cnt", 32'(stall_cycles_a), 32'd1);
    // rd_ex = x0 never interlocks
    lu_rs2(5'd0);
    #1 chk("lu_x0_ctl", 32'(ctl_a), 32'h0);
    tick();
    chk("lu_x0_cnt", 32'(stall_cycles_a), 32'd1);
    clr();
    // Load-use on rs1, then the same match with uses_rs1_id low
    rd_ex = 5'd7; rs1_id = 5'd7; uses_rs1_id = 1'b1; read_mem_ex = 1'b1;
    #1 chk("lu_rs1_ctl", 32'(ctl_a), 32'b1110);
    tick();
    chk("lu_rs1_cnt", 32'(stall_cycles_a), 32'd2);
    uses_rs1_id = 1'b0;
    #1 chk("lu_nouse_ctl", 32'(ctl_a), 32'h0);
    clr();
    tick();

    // Taken jump: flush for exactly 2 cycles, load-use ignored in the second
    jmp_taken_ex = 1'b1;
    #1 chk("jmp_c1_ctl", 32'(ctl_a), 32'b0001);
    tick();
    jmp_taken_ex = 1'b0;
    lu_rs2(5'd5);
    #1 chk("jmp_c2_ctl", 32'(ctl_a), 32'b0001);
    tick();
    clr();
    #1 chk("jmp_c3_ctl", 32'(ctl_a), 32'h0);
    chk("jmp_cnt", 32'(stall_cycles_a), 32'd2);
    tick();

    // Memory wait: 4 stalled cycles then release
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("mw_c%0d_ctl", i), 32'(ctl_a), 32'b1100);
      if (i == 0) chk("b_in_reset_ctl", 32'(ctl_b), 32'h0);
      tick();
    end
    mem_ready = 1'b1;
    #1 chk("mw_rel_ctl", 32'(ctl_a), 32'h0);
    tick();
    clr();
    #1 chk("mw_cnt", 32'(stall_cycles_a), 32'd6);
    chk("mw_tmo", 32'(mem_timeout_a), 32'd0);
    tick();

    // Jump during a memory wait: flush deferred to the release cycle
    mem_req = 1'b1; mem_ready = 1'b0; jmp_taken_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("jw_c%0d_ctl", i), 32'(ctl_a), 32'b1100);
      tick();
    end
    mem_ready = 1'b1;
    #1 chk("jw_rel_ctl", 32'(ctl_a), 32'b0001);
    tick();
    clr();
    #1 chk("jw_fl2_ctl", 32'(ctl_a), 32'b0001);
    tick();
    chk("jw_done_ctl", 32'(ctl_a), 32'h0);
    chk("jw_cnt", 32'(stall_cycles_a), 32'd9);

    // Reset while in MEM_WAIT
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    rst_n_a = 1'b0;
    #1 chk("rmw_ctl_in_rst", 32'(ctl_a), 32'h0);
    tick();
    rst_n_a = 1'b1;
    clr();
    #1 chk("rmw_cnt", 32'(stall_cycles_a), 32'd0);
    lu_rs2(5'd3);
    #1 chk("rmw_run_ctl", 32'(ctl_a), 32'b1110);
    tick();
    clr();

    // Reset while in FLUSH
    jmp_taken_ex = 1'b1;
    tick();
    jmp_taken_ex = 1'b0;
    rst_n_a = 1'b0;
    #1 chk("rfl_ctl_in_rst", 32'(ctl_a), 32'h0);
    tick();
    rst_n_a = 1'b1;
    #1 chk("rfl_cnt", 32'(stall_cycles_a), 32'd0);
    lu_rs2(5'd9);
    #1 chk("rfl_run_ctl", 32'(ctl_a), 32'b1110);
    tick();
    clr();
    rst_n_a = 1'b0;

    // dut_b: timeout after the 3rd wait cycle, sticky after release
    rst_n_b = 1'b1;
    tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("tmo_c%0d", i), 32'(mem_timeout_b), (i >= 2) ? 32'd1 : 32'd0);
    end
    mem_ready = 1'b1;
    #1 chk("tmo_rel_ctl", 32'(ctl_b), 32'h0);
    tick();
    clr();
    tick();
    chk("tmo_sticky", 32'(mem_timeout_b), 32'd1);
    chk("tmo_cnt", 32'(stall_cycles_b), 32'd5);

    // Saturation: 15 more stall cycles (20 total) on a 4-bit counter
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    tick();
    clr();
    chk("sat_cnt", 32'(stall_cycles_b), 32'd15);

    // Flush (3 cycles) suspended by a memory wait, resumed with preserved count
    jmp_taken_ex = 1'b1;
    #1 chk("sus_f1_ctl", 32'(ctl_b), 32'b0001);
    tick();
    jmp_taken_ex = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 chk("sus_w1_ctl", 32'(ctl_b), 32'b1100);
    tick();
    #1 chk("sus_w2_ctl", 32'(ctl_b), 32'b1100);
    tick();
    mem_ready = 1'b1;
    #1 chk("sus_f2_ctl", 32'(ctl_b), 32'b0001);
    tick();
    clr();
    #1 chk("sus_f3_ctl", 32'(ctl_b), 32'b0001);
    tick();
    lu_rs2(5'd4);
    #1 chk("sus_run_ctl", 32'(ctl_b), 32'b1110);
    tick();
    clr();
    chk("sat_hold_cnt", 32'(stall_cycles_b), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the hold, bubble and flush controls of the PC, IF/ID and ID/EX registers. It detects load-use hazards, freezes the pipe while data memory is busy, and issues a multi-cycle flush after a taken jump resolved in EX. It also keeps a saturating stall-cycle performance counter and a sticky memory-timeout flag.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles flush is asserted after a taken jump; legal range 1-3.
MEM_TIMEOUT, 255, consecutive memory wait cycles after which mem_timeout sets; legal range 1-65535.
CNT_W, 16, width of stall_cycles.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
rs1_id  in  5  rs1 index of the instruction in ID
rs2_id  in  5  rs2 index of the instruction in ID
uses_rs1_id  in  1  ID instruction reads rs1
uses_rs2_id  in  1  ID instruction reads rs2
rd_ex  in  5  destination index of the instruction in EX
read_mem_ex  in  1  EX instruction is a load
jmp_taken_ex  in  1  EX instruction redirects the PC this cycle
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID and ID/EX data fields
id_stall_req  out  1  force ID/EX control fields to bubble
flush  out  1  clear IF/ID and ID/EX
mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset, and every cycle rst_n=0: state=RUN, flush counter=0, wait counter=0, jmp_pending=0, mem_timeout=0, stall_cycles=0.
- Control outputs pc_stall, if_id_stall, id_stall_req and flush are combinational from state and the current inputs. All are 0 while rst_n=0.
- Internal: load_use = read_mem_ex & (rd_ex!=0) & ((uses_rs1_id & rs1_id==rd_ex) | (uses_rs2_id & rs2_id==rd_ex)). mem_wait = mem_req & ~mem_ready.
- Per-cycle priority: mem_wait > flush sequence > load_use.
- State RUN:
  - mem_wait: pc_stall=1, if_id_stall=1, id_stall_req=0, flush=0. Latch jmp_pending=jmp_taken_ex. Next state MEM_WAIT; wait counter=1.
  - else jmp_taken_ex: flush=1, all other controls 0. Next state FLUSH if FLUSH_CYCLES>1 (counter=FLUSH_CYCLES-1), else RUN.
  - else load_use: pc_stall=1, if_id_stall=1, id_stall_req=1 for exactly this cycle. Stay in RUN; the hazard clears naturally as the load advances.
  - else: all controls 0.
- State FLUSH: flush=1. Decrement the counter and return to RUN when it reaches 0. load_use and jmp_taken_ex are ignored, since the instruction in EX is a flushed bubble. mem_wait takes priority: the flush is suspended and the remaining count is preserved in MEM_WAIT.
- State MEM_WAIT: pc_stall=1, if_id_stall=1, other controls 0; wait counter increments, saturating.
  - Wait counter reaching MEM_TIMEOUT sets mem_timeout. mem_timeout clears only on reset.
  - On mem_req=0 or mem_ready=1: exit in that same cycle with controls 0.
  - Exit with jmp_pending=1, or a nonzero saved flush count: flush=1 this cycle; continue in FLUSH if more cycles remain, else RUN.
  - Clear jmp_pending and the wait counter on exit.
- stall_cycles increments at each clock edge where pc_stall=1 and saturates at all-ones; it never wraps.
- No output is ever X or Z after reset.

Test Plan:
- Load-use: rd_ex=5, read_mem_ex=1, rs2_id=5, uses_rs2_id=1 -> pc_stall=if_id_stall=id_stall_req=1 for 1 cycle, flush=0; stall_cycles=1. Same with rd_ex=0 -> no stall.
- Taken jump, FLUSH_CYCLES=2: jmp_taken_ex=1 for 1 cycle -> flush=1 for exactly 2 cycles; a load_use pattern during cycle 2 causes no stall.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> pc_stall=if_id_stall=1 for 4 cycles, id_stall_req=0; stall_cycles=4; mem_timeout=0.
- Jump during wait: mem_wait and jmp_taken_ex together for 3 cycles, then mem_ready=1 -> no flush during the wait; flush=1 on the release cycle.
- Timeout/saturation: MEM_TIMEOUT=3, wait of 5 cycles -> mem_timeout rises after the 3rd wait cycle and stays 1 after release. CNT_W=4, 20 stall cycles -> stall_cycles=15.
- Reset mid-operation: rst_n=0 during MEM_WAIT and during FLUSH -> next cycle all outputs 0, state RUN, counters 0.
